// File: rtl/uart_transmitter_if.sv
// Byte-in / serial-out port bundle of the UART transmitter.
// Handshake: TX_EN acts as valid and TX_STATUS as ready; a byte transfers on a rising edge where both are 1.
interface uart_transmitter_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] TX_DATA;
  logic                 TX_EN;
  logic                 UART_TX;
  logic                 TX_STATUS;

  modport master (
    output TX_DATA,
    output TX_EN,
    input  UART_TX,
    input  TX_STATUS
  );

  modport slave (
    input  TX_DATA,
    input  TX_EN,
    output UART_TX,
    output TX_STATUS
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmit engine: start bit, LSB-first data, optional parity, 1-2 stop bits,
// each bit held for OVERSAMPLE cycles of the oversampled baud clock.
module uart_transmitter #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                BaudRate_clk,
  input  logic                reset,
  uart_transmitter_if.slave   tx_if,
  output logic [2:0]          dbg_state_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] OS_LAST   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          os_q, os_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   status_q, status_d;
  logic                   wrap;

  always_ff @(posedge BaudRate_clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      os_q     <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      status_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      os_q     <= os_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      status_q <= status_d;
    end
  end

  // tx_d/status_d are the values the line will carry after this edge, so outputs stay registered.
  always_comb begin
    state_d  = state_q;
    os_d     = os_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    status_d = status_q;
    wrap     = (os_q == OS_LAST);

    if (state_q != S_IDLE) begin
      os_d = wrap ? '0 : os_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d     = 1'b1;
        status_d = 1'b1;
        if (tx_if.TX_EN) begin
          shift_d  = tx_if.TX_DATA;
          par_d    = (PARITY == 1) ? ~(^tx_if.TX_DATA) : (^tx_if.TX_DATA);
          os_d     = '0;
          bit_d    = '0;
          tx_d     = 1'b0;
          status_d = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (wrap) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (wrap) begin
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (wrap) begin
          state_d = S_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (wrap) begin
          if (bit_q == STOP_LAST) begin
            state_d  = S_IDLE;
            bit_d    = '0;
            status_d = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        tx_d     = 1'b1;
        status_d = 1'b1;
      end
    endcase
  end

  assign tx_if.UART_TX   = tx_q;
  assign tx_if.TX_STATUS = status_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three configurations share one TX_EN/TX_DATA stream,
// each with its own expected queue and a line monitor decoding the serial output.
module tb_uart_transmitter;

  localparam int NK = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_en;
  logic [7:0]  tx_data;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [2:0]  dbg_a, dbg_b, dbg_c;
  logic [31:0] next_free [NK];
  logic [39:0] exp_q0[$];
  logic [39:0] exp_q1[$];
  logic [39:0] exp_q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_transmitter_if #(.DATA_BITS(8)) if_a ();
  uart_transmitter_if #(.DATA_BITS(8)) if_b ();
  uart_transmitter_if #(.DATA_BITS(5)) if_c ();

  assign if_a.TX_EN   = tx_en;
  assign if_a.TX_DATA = tx_data;
  assign if_b.TX_EN   = tx_en;
  assign if_b.TX_DATA = tx_data;
  assign if_c.TX_EN   = tx_en;
  assign if_c.TX_DATA = tx_data[4:0];

  uart_transmitter #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .BaudRate_clk(clk), .reset(rst_n), .tx_if(if_a.slave), .dbg_state_o(dbg_a));
  uart_transmitter #(.OVERSAMPLE(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_b (
    .BaudRate_clk(clk), .reset(rst_n), .tx_if(if_b.slave), .dbg_state_o(dbg_b));
  uart_transmitter #(.OVERSAMPLE(2), .DATA_BITS(5), .PARITY(1), .STOP_BITS(1)) dut_c (
    .BaudRate_clk(clk), .reset(rst_n), .tx_if(if_c.slave), .dbg_state_o(dbg_c));

  wire [NK-1:0] line_w   = {if_c.UART_TX, if_b.UART_TX, if_a.UART_TX};
  wire [NK-1:0] status_w = {if_c.TX_STATUS, if_b.TX_STATUS, if_a.TX_STATUS};

  // Configuration of each instance, restated for the reference model.
  function automatic int f_os(input int k);
    case (k) 0: return 16; 1: return 4; default: return 2; endcase
  endfunction
  function automatic int f_db(input int k);
    case (k) 0: return 8; 1: return 8; default: return 5; endcase
  endfunction
  function automatic int f_par(input int k);
    case (k) 0: return 0; 1: return 2; default: return 1; endcase
  endfunction
  function automatic int f_sb(input int k);
    case (k) 0: return 1; 1: return 2; default: return 1; endcase
  endfunction
  function automatic int f_len(input int k);
    return (1 + f_db(k) + ((f_par(k) != 0) ? 1 : 0) + f_sb(k)) * f_os(k);
  endfunction

  // Expected line levels, one per bit period, in transmission order.
  function automatic logic [15:0] frame_bits(input int k, input logic [7:0] d);
    logic [15:0] v;
    int n;
    int ones;
    v = '0;
    n = 1;
    ones = 0;
    for (int i = 0; i < f_db(k); i++) begin
      v[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (f_par(k) == 1) begin
      v[n] = ((ones % 2) == 0);
      n++;
    end else if (f_par(k) == 2) begin
      v[n] = ((ones % 2) == 1);
      n++;
    end
    for (int s = 0; s < f_sb(k); s++) begin
      v[n] = 1'b1;
      n++;
    end
    return v;
  endfunction

  function automatic void q_push(input int k, input logic [39:0] v);
    case (k)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction
  function automatic logic [39:0] q_pop(input int k);
    case (k)
      0: return exp_q0.pop_front();
      1: return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction
  function automatic int q_size(input int k);
    case (k)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, k, act, exp, cyc);
    end
  endtask

  // One bench cycle: drive inputs after a falling edge, let the model decide acceptance.
  task automatic step(input logic en, input logic [7:0] d);
    logic [31:0] e;
    tx_en   = en;
    tx_data = d;
    e = cyc + 1;
    if (en) begin
      for (int k = 0; k < NK; k++) begin
        if (e >= next_free[k]) begin
          q_push(k, {e, d});
          next_free[k] = e + 32'(f_len(k)) + 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
  endtask

  task automatic monitor(input int k);
    int          os, nb, glitches, busy_bad;
    logic [15:0] bits;
    logic [31:0] t0;
    logic [39:0] e;
    logic        aborted;
    os = f_os(k);
    nb = f_len(k) / os;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || line_w[k] !== 1'b0) continue;
      t0 = cyc;
      bits = '0;
      glitches = 0;
      busy_bad = 0;
      aborted = 1'b0;
      for (int b = 0; b < nb; b++) begin
        for (int s = 0; s < os; s++) begin
          if (b != 0 || s != 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (s == 0) bits[b] = line_w[k];
          else if (line_w[k] !== bits[b]) glitches++;
          if (status_w[k] !== 1'b0) busy_bad++;
        end
        if (aborted) break;
      end
      if (aborted) continue;
      @(negedge clk);
      if (rst_n !== 1'b1) continue;
      check("status_after_frame", k, 32'(status_w[k]), 32'd1);
      check("line_after_frame", k, 32'(line_w[k]), 32'd1);
      if (q_size(k) == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame dut%0d: got frame %0h at cycle %0d expected none", k, bits, t0);
      end else begin
        e = q_pop(k);
        check("frame_start", k, t0, e[39:8]);
        check("frame_bits", k, 32'(bits), 32'(frame_bits(k, e[7:0])));
        check("bit_hold", k, 32'(glitches), 32'd0);
        check("busy_status", k, 32'(busy_bad), 32'd0);
      end
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
  end

  initial begin
    rst_n   = 1'b0;
    tx_en   = 1'b0;
    tx_data = 8'h00;
    for (int k = 0; k < NK; k++) next_free[k] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NK; k++) begin
      check("reset_line", k, 32'(line_w[k]), 32'd1);
      check("reset_status", k, 32'(status_w[k]), 32'd1);
    end
    rst_n = 1'b1;
    idle(4);

    // Single frames, then a request landing mid-frame.
    step(1'b1, 8'hA5);
    idle(200);
    step(1'b1, 8'h3C);
    idle(49);
    step(1'b1, 8'hFF);
    idle(200);

    // Asynchronous reset part-way through a frame.
    step(1'b1, 8'h96);
    idle(69);
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    for (int k = 0; k < NK; k++) next_free[k] = '0;
    #1;
    for (int k = 0; k < NK; k++) begin
      check("async_reset_line", k, 32'(line_w[k]), 32'd1);
      check("async_reset_status", k, 32'(status_w[k]), 32'd1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    step(1'b1, 8'hC3);
    idle(200);

    // Random sparse requests.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 15) == 0, 8'($urandom));
    end

    // TX_EN held high with data changing every cycle.
    for (int i = 0; i < 700; i++) begin
      step(1'b1, 8'($urandom));
    end
    idle(250);

    for (int k = 0; k < NK; k++) begin
      check("drain_queue", k, 32'(q_size(k)), 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- UART transmit engine; the transmit-side counterpart of the team's UART Receiver.
- Driven by the same BaudRate_clk, which runs at OVERSAMPLE times the bit rate (16x by default).
- Accepts one parallel byte per handshake and serialises it onto UART_TX as start bit, DATA_BITS data bits (LSB first), an optional parity bit, and STOP_BITS stop bits.
- Frame timing matches what the Receiver expects, so the two blocks can be connected back-to-back for loopback.

Parameters:
- OVERSAMPLE, 16: BaudRate_clk cycles per serial bit; legal range 2..256.
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- BaudRate_clk  input  1  single clock, oversampled baud clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- TX_DATA  input  DATA_BITS  byte to send; sampled only on the accepting edge.
- TX_EN  input  1  send request; qualified by TX_STATUS=1.
- UART_TX  output  1  serial line, idle high.
- TX_STATUS  output  1  1 = idle and ready to accept; 0 = frame in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; UART_TX=1; TX_STATUS=1.
  - Bit counter, oversample counter and shift register cleared.
  - Takes effect immediately, mid-frame included: the line returns high at once and the partial frame is abandoned, never resumed.
- Outputs are registered; no combinational path from any input to UART_TX or TX_STATUS.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - UART_TX=1, TX_STATUS=1.
  - On an edge N with TX_EN=1: latch TX_DATA into the shift register, compute the parity bit from the latched value, go to START.
  - After edge N: UART_TX=0 and TX_STATUS=0.
- Bit timing:
  - Every bit is held for exactly OVERSAMPLE cycles.
  - An oversample counter runs 0..OVERSAMPLE-1; the bit/state advances on the edge where the counter wraps.
- START lasts one bit period, then DATA.
- DATA:
  - Shifts out bit 0 first; DATA_BITS bit periods.
  - Then PARITY if PARITY != 0, otherwise STOP.
- PARITY bit value:
  - odd mode: XOR of data bits, inverted;
  - even mode: XOR of data bits.
  - Lasts one bit period.
- STOP:
  - UART_TX=1 for STOP_BITS bit periods, then IDLE.
  - TX_STATUS returns to 1 on the same edge the FSM enters IDLE.
- Frame length: F = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * OVERSAMPLE cycles; the default is F = 160.
  - TX_STATUS is 0 over edges N..N+F-1 and returns to 1 after edge N+F.
- Earliest next acceptance is edge N+F+1, which guarantees at least one idle-high clock between frames.
- TX_EN while TX_STATUS=0 is ignored: TX_DATA is not sampled and no request is queued.
- TX_EN held high continuously gives back-to-back frames every F+1 cycles, each with the TX_DATA present on its accepting edge.
- TX_DATA changes after the accepting edge do not affect the frame in flight.
- Counter widths: the oversample counter is wide enough for OVERSAMPLE-1 and the bit counter for DATA_BITS-1; no other arithmetic.

Test Plan:
- Basic frame, defaults, TX_DATA=8'hA5, 1-cycle TX_EN pulse at edge N:
  - UART_TX over successive 16-cycle windows = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
  - TX_STATUS=0 for 160 cycles and is back to 1 after edge N+160.
- Busy rejection: send 8'h3C; pulse TX_EN with TX_DATA=8'hFF at cycle 50 of the frame -> serial output is still exactly 8'h3C, and no second frame follows.
- Loopback:
  - Drive the Receiver's UART_RX from UART_TX on a shared BaudRate_clk; send 8'h00, 8'hFF, 8'h55 back-to-back with TX_EN held high.
  - Each RX_DATA matches in order and RX_STATUS flags each byte.
  - Frame starts are spaced 161 cycles apart.
- Parity, PARITY=2 (even), TX_DATA=8'h07 -> parity bit window = 1, frame = 176 cycles.
  - Same with PARITY=1 (odd) -> parity bit = 0.
- Reset mid-frame: assert reset (low) at cycle 70 of a frame, asynchronously between edges.
  - UART_TX=1 and TX_STATUS=1 immediately.
  - After release, a new TX_EN with 8'hC3 produces a clean, complete frame.
- Two stop bits, OVERSAMPLE=4, STOP_BITS=2, TX_DATA=8'h80 -> UART_TX high for the final 8 cycles; frame = 44 cycles.
